// File: rtl/demux_32_pipe_pkg.sv
// demux_32_pipe_pkg: shared constants for the registered 1:2 result demultiplexer.
// Holds the port-select encodings and the default geometry used by the top and FIFOs.
package demux_32_pipe_pkg;

  // Destination encodings carried on in_sel
  localparam logic SEL_PORT_A = 1'b0;
  localparam logic SEL_PORT_B = 1'b1;

  // Default geometry: 32-bit beats, 2-entry FIFO per port, counter holds 0..DEPTH
  localparam int DEMUX_BUS_WIDTH = 32;
  localparam int DEMUX_DEPTH     = 2;
  localparam int DEMUX_CNT_W     = 2;

endpackage

// File: rtl/demux_32_pipe_fifo.sv
// demux_fifo: single-clock synchronous FIFO with synchronous active-low reset.
// Reset clears pointers, occupancy and storage so the head reads as zero afterwards.
// Full is derived from the registered count only; a pop never frees space for a
// push in the same cycle.
module demux_fifo
  import demux_32_pipe_pkg::*;
#(
  parameter int BUS_WIDTH = DEMUX_BUS_WIDTH,
  parameter int DEPTH     = DEMUX_DEPTH,
  parameter int CNT_W     = DEMUX_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [BUS_WIDTH-1:0] i_data,
  input  logic                 i_pop,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [BUS_WIDTH-1:0] o_data
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = !(r_count < DEPTH_C);
  assign o_empty   = (r_count == CNT_ZERO);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage write on an accepted push; cleared on reset so an empty head reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointer advance: power-of-two depth lets both pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= CNT_ZERO;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + CNT_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      r_count <= r_count - CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/demux_32_pipe.sv
// demux_32_pipe: registered 1:2 demultiplexer splitting one result stream into
// port A / port B, each behind its own demux_fifo so a stalled consumer only
// blocks beats bound for its own port.
// Optional build macro: DEMUX_32_PIPE_STATS_EN adds a_beats, b_beats and stall_seen.
module demux_32_pipe
  import demux_32_pipe_pkg::*;
#(
  parameter int BUS_WIDTH = DEMUX_BUS_WIDTH,
  parameter int DEPTH     = DEMUX_DEPTH,
  parameter int CNT_W     = DEMUX_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] a_data,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [BUS_WIDTH-1:0] b_data,
  output logic                 b_valid,
`ifdef DEMUX_32_PIPE_STATS_EN
  input  logic                 b_ready,
  output logic [15:0]          a_beats,
  output logic [15:0]          b_beats,
  output logic                 stall_seen
`else
  input  logic                 b_ready
`endif
);

  logic w_full_a;
  logic w_full_b;
  logic w_empty_a;
  logic w_empty_b;
  logic w_push_a;
  logic w_push_b;
  logic w_pop_a;
  logic w_pop_b;

  // Ready depends only on the selected port's registered occupancy, never on x_ready
  assign in_ready = (in_sel == SEL_PORT_B) ? !w_full_b : !w_full_a;
  assign w_push_a = in_valid && in_ready && (in_sel == SEL_PORT_A);
  assign w_push_b = in_valid && in_ready && (in_sel == SEL_PORT_B);
  assign a_valid  = !w_empty_a;
  assign b_valid  = !w_empty_b;
  assign w_pop_a  = a_valid && a_ready;
  assign w_pop_b  = b_valid && b_ready;

  demux_fifo #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_a),
    .i_data  (in_data),
    .i_pop   (w_pop_a),
    .o_full  (w_full_a),
    .o_empty (w_empty_a),
    .o_data  (a_data)
  );

  demux_fifo #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_b),
    .i_data  (in_data),
    .i_pop   (w_pop_b),
    .o_full  (w_full_b),
    .o_empty (w_empty_b),
    .o_data  (b_data)
  );

`ifdef DEMUX_32_PIPE_STATS_EN
  logic [15:0] r_a_beats;
  logic [15:0] r_b_beats;
  logic        r_stall_seen;

  // Per-port accepted-beat counters (wrap at 16 bits) and sticky producer-stall flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_beats    <= 16'd0;
      r_b_beats    <= 16'd0;
      r_stall_seen <= 1'b0;
    end else begin
      if (w_push_a) begin
        r_a_beats <= r_a_beats + 16'd1;
      end else begin
        r_a_beats <= r_a_beats;
      end
      if (w_push_b) begin
        r_b_beats <= r_b_beats + 16'd1;
      end else begin
        r_b_beats <= r_b_beats;
      end
      if (in_valid && !in_ready) begin
        r_stall_seen <= 1'b1;
      end else begin
        r_stall_seen <= r_stall_seen;
      end
    end
  end

  assign a_beats    = r_a_beats;
  assign b_beats    = r_b_beats;
  assign stall_seen = r_stall_seen;
`endif

endmodule

// File: tb/tb_demux_32_pipe.sv
// tb_demux_32_pipe: directed self-checking bench for demux_32_pipe (DEPTH = 2).
// Stats checks are compiled in only when DEMUX_32_PIPE_STATS_EN is defined.
module tb_demux_32_pipe;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
`ifdef DEMUX_32_PIPE_STATS_EN
  logic [15:0] a_beats;
  logic [15:0] b_beats;
  logic        stall_seen;
`endif

  int n_cmp;
  int n_err;

  demux_32_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
`ifdef DEMUX_32_PIPE_STATS_EN
    .b_ready    (b_ready),
    .a_beats    (a_beats),
    .b_beats    (b_beats),
    .stall_seen (stall_seen)
`else
    .b_ready    (b_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_data  = 32'h0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_b_data", b_data, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_32_PIPE_STATS_EN
    chk("rst_a_beats", {16'd0, a_beats}, 32'd0);
    chk("rst_stall", {31'd0, stall_seen}, 32'd0);
`endif

    // 1: single beat to A, one-cycle latency, popped next edge
    in_data = 32'hDEADBEEF; in_sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1;
    #1;
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t1_a_valid", {31'd0, a_valid}, 32'd1);
    chk("t1_a_data", a_data, 32'hDEADBEEF);
    chk("t1_b_valid", {31'd0, b_valid}, 32'd0);
    tick();
    chk("t1_a_popped", {31'd0, a_valid}, 32'd0);

    // 2: fill A, A-bound beat stalls, B-bound beat passes
    a_ready = 1'b0;
    in_data = 32'h1; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h2;
    tick();
    in_data = 32'h3;
    #1;
    chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_a_head", a_data, 32'h1);
    tick();
    in_data = 32'h4; in_sel = 1'b1;
    #1;
    chk("t2_b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t2_b_valid", {31'd0, b_valid}, 32'd1);
    chk("t2_b_data", b_data, 32'h4);
    chk("t2_a_hold", a_data, 32'h1);
    b_ready = 1'b1;
    tick();
    chk("t2_b_drained", {31'd0, b_valid}, 32'd0);
    b_ready = 1'b0;

    // 3: A full, push + pop same cycle -> push refused, accepted next cycle
    in_data = 32'h3; in_sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1;
    #1;
    chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
    tick();
    a_ready = 1'b0;
    #1;
    chk("t3_head2", a_data, 32'h2);
    chk("t3_ready_free", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_still2", a_data, 32'h2);
    a_ready = 1'b1;
    tick();
    chk("t3_head3_v", {31'd0, a_valid}, 32'd1);
    chk("t3_head3", a_data, 32'h3);
    tick();
    chk("t3_empty", {31'd0, a_valid}, 32'd0);

    // 4: 10 alternating beats, both consumers always ready
    b_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data  = 32'h100 + 32'(k);
      in_sel   = k[0];
      in_valid = 1'b1;
      tick();
      if (k[0]) begin
        chk("t4_b_valid", {31'd0, b_valid}, 32'd1);
        chk("t4_b_data", b_data, 32'h100 + 32'(k));
        chk("t4_a_idle", {31'd0, a_valid}, 32'd0);
      end else begin
        chk("t4_a_valid", {31'd0, a_valid}, 32'd1);
        chk("t4_a_data", a_data, 32'h100 + 32'(k));
        chk("t4_b_idle", {31'd0, b_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t4_a_end", {31'd0, a_valid}, 32'd0);
    chk("t4_b_end", {31'd0, b_valid}, 32'd0);

    // 5: reset while A is full and B holds a beat
    a_ready = 1'b0; b_ready = 1'b0;
    in_data = 32'h55; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h66;
    tick();
    in_data = 32'h77; in_sel = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_pre_a", {31'd0, a_valid}, 32'd1);
    chk("t5_pre_b", b_data, 32'h77);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_sel = 1'b0;
    #1;
    chk("t5_a_valid", {31'd0, a_valid}, 32'd0);
    chk("t5_b_valid", {31'd0, b_valid}, 32'd0);
    chk("t5_a_data", a_data, 32'h0);
    chk("t5_b_data", b_data, 32'h0);
    chk("t5_ready_a", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1;
    #1;
    chk("t5_ready_b", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_32_PIPE_STATS_EN
    chk("t5_a_beats", {16'd0, a_beats}, 32'd0);
    chk("t5_b_beats", {16'd0, b_beats}, 32'd0);
    chk("t5_stall", {31'd0, stall_seen}, 32'd0);
`endif

    // 6: 3 beats to A (with a stall), 5 beats to B
    a_ready = 1'b0; b_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_data = 32'hA3;
`ifdef DEMUX_32_PIPE_STATS_EN
    chk("t6_no_stall_yet", {31'd0, stall_seen}, 32'd0);
`endif
    tick();
    a_ready = 1'b1;
    tick();
    #1;
    chk("t6_a3_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_sel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'hB0 + 32'(k);
      tick();
      chk("t6_b_data", b_data, 32'hB0 + 32'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("t6_a_drained", {31'd0, a_valid}, 32'd0);
`ifdef DEMUX_32_PIPE_STATS_EN
    chk("t6_a_beats", {16'd0, a_beats}, 32'd3);
    chk("t6_b_beats", {16'd0, b_beats}, 32'd5);
    chk("t6_stall", {31'd0, stall_seen}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
